// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: decodes the held instruction and sequences datapath steps.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; illegal encodings trap to HALT or retire as NOP.
// No backpressure: one state per clock, and only PCWrite looks at Zero combinationally.
module multicycle_controller #(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_HALT
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       instr_legal;
    logic [2:0] funct_alu;

    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       halted;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_ctl;

    // Legality covers the opcode and, for ALU ops, the funct3 field.
    always_comb begin
        instr_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_JAL, OP_BEQ: instr_legal = 1'b1;
            OP_R, OP_I: begin
                case (funct3)
                    3'b000, 3'b010, 3'b110, 3'b111: instr_legal = 1'b1;
                    default:                        instr_legal = 1'b0;
                endcase
            end
            default: instr_legal = 1'b0;
        endcase
    end

    // funct7b5 only selects sub for R-type; addi ignores it.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (!instr_legal) begin
                    state_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_R:         state_next = S_EXECR;
                        OP_I:         state_next = S_EXECI;
                        OP_JAL:       state_next = S_JAL;
                        OP_BEQ:       state_next = S_BEQ;
                        default:      state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore outputs per state, before reset gating.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_ctl    = ALU_ADD;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
            end
            S_MEMADR: begin
                src_a = 2'b10;
                src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                src_a   = 2'b10;
                alu_ctl = funct_alu;
            end
            S_EXECI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_ctl = funct_alu;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_JAL: begin
                src_a     = 2'b01;
                src_b     = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                src_a   = 2'b10;
                alu_ctl = ALU_SUB;
                branch  = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // Enables are held low for the whole reset pulse, even though the state is already FETCH.
    always_comb begin
        PCWrite    = ~reset & (pc_update | (branch & Zero));
        IRWrite    = ~reset & ir_write;
        MemWrite   = ~reset & mem_write;
        RegWrite   = ~reset & reg_write;
        Illegal    = ~reset & halted;
        AdrSrc     = adr_src;
        ResultSrc  = result_src;
        ALUSrcA    = src_a;
        ALUSrcB    = src_b;
        ALUControl = alu_ctl;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected step lists, random and directed programs.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       ir;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
        logic       ill;
    } vec_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset_nt = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;

    logic       pcw0, adr0, mw0, ir0, rw0, ill0;
    logic [1:0] rs0, a0, b0, imm0;
    logic [2:0] alu0;
    logic       pcw1, adr1, mw1, ir1, rw1, ill1;
    logic [1:0] rs1, a1, b1, imm1;
    logic [2:0] alu1;
    vec_t       obs0, obs1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(ir0), .RegWrite(rw0),
        .ResultSrc(rs0), .ALUSrcA(a0), .ALUSrcB(b0), .ImmSrc(imm0), .ALUControl(alu0), .Illegal(ill0)
    );

    multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut_nt (
        .clk(clk), .reset(reset_nt), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(ir1), .RegWrite(rw1),
        .ResultSrc(rs1), .ALUSrcA(a1), .ALUSrcB(b1), .ImmSrc(imm1), .ALUControl(alu1), .Illegal(ill1)
    );

    assign obs0 = {pcw0, adr0, mw0, ir0, rw0, rs0, a0, b0, alu0, ill0};
    assign obs1 = {pcw1, adr1, mw1, ir1, rw1, rs1, a1, b1, alu1, ill1};

    function automatic vec_t v(input logic pcw, input logic adr, input logic mw, input logic ir,
                               input logic rw, input logic [1:0] rs, input logic [1:0] a,
                               input logic [1:0] b, input logic [2:0] alu, input logic ill);
        vec_t r;
        r = {pcw, adr, mw, ir, rw, rs, a, b, alu, ill};
        return r;
    endfunction

    // Reference ALU operation from the funct3 table.
    function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == RT && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == SW)  return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit legal_ref(input logic [6:0] o, input logic [2:0] f3);
        if (o == LW || o == SW || o == JAL || o == BEQ) return 1'b1;
        if (o == RT || o == IT) return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH; limit>0 stops before checking step number limit.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input bit sel, input bit trap, input int zmode, input int limit);
        vec_t q[$];
        bit   zd[$];
        vec_t e;
        logic [2:0] alu;
        alu = alu_ref(o, f3, f7);
        q.push_back(v(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0)); zd.push_back(0);
        q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0)); zd.push_back(0);
        if (!legal_ref(o, f3)) begin
            if (trap) begin
                for (int k = 0; k < 10; k++) begin
                    q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1)); zd.push_back(0);
                end
            end
        end else if (o == LW || o == SW) begin
            q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0)); zd.push_back(0);
            if (o == LW) begin
                q.push_back(v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0)); zd.push_back(0);
                q.push_back(v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0)); zd.push_back(0);
            end else begin
                q.push_back(v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0)); zd.push_back(0);
            end
        end else if (o == RT || o == IT || o == JAL) begin
            if (o == RT)
                q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0));
            else if (o == IT)
                q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0));
            else
                q.push_back(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0));
            zd.push_back(0);
            q.push_back(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0)); zd.push_back(0);
        end else begin
            q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0)); zd.push_back(1);
        end
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        for (int i = 0; i < q.size(); i++) begin
            if (limit > 0 && i >= limit) break;
            Zero = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 2);
            #2;
            e = q[i];
            if (zd[i]) e.pcw = Zero;
            chk($sformatf("op%b_f%0d_step%0d_dut%0d", o, f3, i, sel), sel ? obs1 : obs0, e);
            chk($sformatf("imm_op%b_step%0d_dut%0d", o, i, sel),
                {13'd0, (sel ? imm1 : imm0)}, {13'd0, imm_ref(o)});
            @(posedge clk);
            #1;
        end
    endtask

    vec_t v_rst;
    logic [6:0] rop;
    logic [2:0] rf3;
    logic [2:0] f3tab [4];

    initial begin
        v_rst = v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        f3tab[0] = 3'd0; f3tab[1] = 3'd2; f3tab[2] = 3'd6; f3tab[3] = 3'd7;

        #1;
        chk("reset_state", obs0, v_rst);
        chk("reset_state_nt", obs1, v_rst);
        @(posedge clk);
        #4;
        chk("reset_hold", obs0, v_rst);
        reset = 1'b0;

        // Directed instruction forms.
        run_instr(RT, 3'd0, 1'b1, 0, 1, 0, 0);   // sub
        run_instr(LW, 3'd2, 1'b0, 0, 1, 0, 0);
        run_instr(SW, 3'd2, 1'b0, 0, 1, 0, 0);
        run_instr(BEQ, 3'd0, 1'b0, 0, 1, 2, 0);  // taken
        run_instr(BEQ, 3'd0, 1'b0, 0, 1, 1, 0);  // not taken
        run_instr(IT, 3'd0, 1'b1, 0, 1, 0, 0);   // addi keeps add
        run_instr(JAL, 3'd0, 1'b0, 0, 1, 0, 0);
        run_instr(RT, 3'd7, 1'b0, 0, 1, 0, 0);
        run_instr(IT, 3'd2, 1'b0, 0, 1, 0, 0);

        // Random program of legal instructions.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0:       rop = LW;
                1:       rop = SW;
                2:       rop = RT;
                3:       rop = IT;
                4:       rop = JAL;
                default: rop = BEQ;
            endcase
            rf3 = (rop == RT || rop == IT) ? f3tab[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
            run_instr(rop, rf3, 1'($urandom_range(0, 1)), 0, 1, 0, 0);
        end

        // Reset pulse of 3ns inside MEMREAD, away from any clock edge.
        run_instr(LW, 3'd2, 1'b0, 0, 1, 0, 3);
        #1;
        chk("memread_before_abort", obs0, v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        #1;
        reset = 1'b1;
        #1;
        chk("abort_in_reset", obs0, v_rst);
        #2;
        reset = 1'b0;
        run_instr(RT, 3'd6, 1'b0, 0, 1, 0, 0);

        // Illegal opcode traps; hold for 10 cycles, then reset recovers.
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 1, 0, 0);
        reset = 1'b1;
        #1;
        chk("halt_reset", obs0, v_rst);
        #2;
        reset = 1'b0;
        run_instr(IT, 3'd6, 1'b0, 0, 1, 0, 0);

        // Illegal funct3 on an R-type follows the same trap policy.
        run_instr(RT, 3'd1, 1'b0, 0, 1, 0, 0);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        run_instr(LW, 3'd2, 1'b0, 0, 1, 0, 0);

        // Non-trapping variant: illegal op retires as NOP straight back to FETCH.
        reset = 1'b1;
        reset_nt = 1'b0;
        run_instr(7'b1111111, 3'd0, 1'b0, 1, 0, 0, 0);
        run_instr(IT, 3'd0, 1'b1, 1, 0, 0, 0);
        run_instr(RT, 3'd4, 1'b0, 1, 0, 0, 0);
        run_instr(BEQ, 3'd0, 1'b0, 1, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
